register_file_mb: RTL
=====================

Name: register_file_mb

Overview:
- Next-generation architectural register file with rename tags for the Tomasulo core; successor to the single-broadcast register file.
- Adds parametrised register count, NUM_BCAST common-data-bus ports, a speculation flush and a registered busy-register counter.
- Sits between the issue stage (read operands, tag destinations) and the CDB arbiter (wake-up).
- Value and tag are stored separately, so a flush restores the last broadcast value.

Parameters:
- DATA_WIDTH, 64, register value width
- NUM_REGS, 32, architectural registers; power of two, 8 or more
- MULTI_ISSUE, 3, issue slots per cycle
- NUM_BCAST, 2, broadcast (CDB) ports per cycle
- SP_RESET, 'h1000, reset value of register 2 (sp)

Ports:
- clk input 1 clock
- rst input 1 asynchronous active-high reset
- issue_wr_en_i input [MULTI_ISSUE]x1 slot i renames a destination
- issue_dst_i input [MULTI_ISSUE]x$clog2(NUM_REGS) destination index
- issue_rs_i input [MULTI_ISSUE]xe_functional_unit producing station tag
- bcast_valid_i input [NUM_BCAST]x1 broadcast valid
- bcast_value_i input [NUM_BCAST]xDATA_WIDTH broadcast result
- bcast_rs_i input [NUM_BCAST]xe_functional_unit broadcasting station
- flush_i input 1 squash all pending renames
- read_reg1_i, read_reg2_i input [MULTI_ISSUE]x$clog2(NUM_REGS) operand indices
- read_virtual1_o, read_virtual2_o output [MULTI_ISSUE]x1 operand still pending
- read_value1_o, read_value2_o output [MULTI_ISSUE]xDATA_WIDTH stored value
- read_tag1_o, read_tag2_o output [MULTI_ISSUE]xe_functional_unit pending tag (valid only when virtual)
- virtual_count_o output $clog2(NUM_REGS)+1 number of virtual registers, registered

Behaviour:
- Reset (async, any time, including mid-flush): all virtual bits 0, all values 0 except reg 2 = SP_RESET, tags 0, virtual_count_o = 0.
- Register 0: reads value 0, virtual 0; never written or tagged.
- Reads are combinational from the current state. Read-after-issue in the same cycle is not forwarded; the issue stage handles intra-bundle dependencies.
- Broadcast, per clock: each reg r>0 with virtual=1 and tag==bcast_rs_i[b] for some valid b:
  - virtual <= 0
  - value <= bcast_value_i[b]
  - The tag field is left unchanged.
- Duplicate valid bcast_rs_i in the same cycle is illegal. Lowest b wins, and a simulation assertion fires.
- Issue, per clock: for each i with issue_wr_en_i[i] and dst != 0:
  - virtual <= 1
  - tag <= issue_rs_i[i]
  - The value field is untouched.
- Same dst in several slots: highest slot index wins.
- Issue and matching broadcast on the same reg in the same cycle: issue wins; the reg stays virtual with the new tag.
- Flush cycle:
  - Broadcasts are applied first (value captured).
  - Then all virtual bits <= 0.
  - All issue writes that cycle are discarded.
  - Result: every reg holds its last broadcast value.
- virtual_count_o: population count of the next-state virtual bits, registered, so it is valid one cycle after the update. Range 0..NUM_REGS-1.
- No handshake; the block is always ready. Latency is 1 cycle from issue or broadcast to visible state.

Optional Feature:
- REGFILE_BCAST_BYPASS_EN
- Defined: if a read port's reg is virtual and its tag matches a valid broadcast in the current cycle, the port returns virtual=0 and value=bcast value combinationally. Lowest b wins. Flush does not affect bypass.
- Undefined: reads reflect only registered state; the woken value appears next cycle.

Decomposition:
- Shared package types.sv holds:
  - e_functional_unit
  - new struct reg_entry_t {is_virtual, rs_id, value}
  - localparam REG_SP = 2
- Sub-module regfile_bcast_match: one instance per register. Takes the tag plus all broadcast ports; outputs a hit flag and the selected value (lowest-index priority). Reused by the bypass path.

Test Plan:
- Reset asserted mid-run, asynchronously with no clock edge -> reg2 reads 'h1000, all others 0, virtual_count_o=0 immediately.
- Issue slot0 dst=5 tag=ALU -> next cycle read5 virtual=1 tag=ALU, count=1. Then bcast0 rs=ALU value=42 -> read5 value=42 virtual=0, count=0.
- Slot0 and slot2 both dst=7 (tags ALU, MUL) -> tag=MUL. Same cycle as a bcast for reg7's old tag -> reg7 stays virtual.
- Two bcast ports waking regs 3 (tag ALU, 11) and 9 (tag MUL, 22) in one cycle -> both resolve, count drops by 2.
- Reg4 value 99 then renamed, flush_i with a concurrent issue to reg6 -> reg4 reads 99 non-virtual, reg6 not virtual, count=0.
- Bypass (macro on): read reg5 pending ALU while bcast ALU=7 -> same cycle returns 7, virtual=0. Macro off -> virtual=1 that cycle.

Source files
------------

// File: rtl/register_file_mb_pkg.sv
// ---------------------------------------------------------------------------
// register_file_mb_pkg
// Shared types for the multi-broadcast rename register file.
//   e_functional_unit : reservation-station tag carried on issue and the CDB
//   reg_entry_t       : one architectural register {is_virtual, rs_id, value}
//   REG_SP            : index of the stack pointer (non-zero reset value)
//   reset_entry()     : reset image of a register entry
// ---------------------------------------------------------------------------
package register_file_mb_pkg;

  typedef enum logic [2:0] {
    FU_NONE   = 3'd0,
    FU_ALU    = 3'd1,
    FU_MUL    = 3'd2,
    FU_DIV    = 3'd3,
    FU_LOAD   = 3'd4,
    FU_STORE  = 3'd5,
    FU_BRANCH = 3'd6
  } e_functional_unit;

  localparam int REG_SP = 2;

  // Storage width of the value field. Narrower DATA_WIDTH builds keep the
  // low bits; the register file never exceeds this width.
  localparam int REG_VALUE_W = 64;

  typedef struct packed {
    logic                   is_virtual;
    e_functional_unit       rs_id;
    logic [REG_VALUE_W-1:0] value;
  } reg_entry_t;

  function automatic reg_entry_t reset_entry(input int idx,
                                             input logic [REG_VALUE_W-1:0] sp_value);
    reg_entry_t e;
    e.is_virtual = 1'b0;
    e.rs_id      = FU_NONE;
    e.value      = (idx == REG_SP) ? sp_value : '0;
    return e;
  endfunction

endpackage

// File: rtl/register_file_mb_bcast_match.sv
// ---------------------------------------------------------------------------
// regfile_bcast_match
// Compares one rename tag against every common-data-bus port and returns the
// value of the matching broadcast. When several valid ports match, the lowest
// port index wins (the loop runs high-to-low so the lowest index is written
// last).
// Ports:
//   i_tag          tag being waited on
//   i_bcast_valid  per-port broadcast valid
//   i_bcast_value  per-port broadcast result
//   i_bcast_rs     per-port broadcasting station
//   o_hit          some valid port carries i_tag
//   o_value        value of the selected port ('0 when no hit)
// ---------------------------------------------------------------------------
module regfile_bcast_match
  import register_file_mb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_BCAST  = 2
) (
  input  e_functional_unit        i_tag,
  input  logic [NUM_BCAST-1:0]    i_bcast_valid,
  input  logic [DATA_WIDTH-1:0]   i_bcast_value [NUM_BCAST],
  input  e_functional_unit        i_bcast_rs    [NUM_BCAST],
  output logic                    o_hit,
  output logic [DATA_WIDTH-1:0]   o_value
);

  always_comb begin
    o_hit   = 1'b0;
    o_value = '0;
    for (int b = NUM_BCAST - 1; b >= 0; b--) begin
      if (i_bcast_valid[b] && (i_bcast_rs[b] == i_tag)) begin
        o_hit   = 1'b1;
        o_value = i_bcast_value[b];
      end
    end
  end

endmodule

// File: rtl/register_file_mb.sv
// ---------------------------------------------------------------------------
// register_file_mb
// Architectural register file with rename tags for the Tomasulo core.
// Each register holds a value, a producing-station tag and a virtual bit.
// Issue marks a destination virtual and records its tag; a CDB broadcast
// whose station matches a pending tag clears the virtual bit and captures the
// value. Value and tag are kept apart, so a flush simply clears every virtual
// bit and each register falls back to its last broadcast value.
//
// Interface: no handshake, always ready. Issue, broadcast and flush are
// sampled on every rising clk edge and are visible on the read ports one
// cycle later. Reads are combinational from the registered state.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   issue_wr_en_i/dst_i/rs_i       per issue slot: rename dst to station rs
//   bcast_valid_i/value_i/rs_i     per CDB port: station rs produced value
//   flush_i                        squash every pending rename
//   read_reg{1,2}_i                per issue slot operand indices
//   read_virtual/value/tag{1,2}_o  operand state (tag meaningful when virtual)
//   virtual_count_o                registered number of virtual registers
//
// Build option: define REGFILE_BCAST_BYPASS_EN to let a read port see a
// same-cycle broadcast for its pending tag; otherwise the woken value appears
// the cycle after the broadcast.
// ---------------------------------------------------------------------------
module register_file_mb
  import register_file_mb_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    NUM_REGS    = 32,
  parameter int                    MULTI_ISSUE = 3,
  parameter int                    NUM_BCAST   = 2,
  parameter logic [DATA_WIDTH-1:0] SP_RESET    = 'h1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MULTI_ISSUE-1:0]        issue_wr_en_i,
  input  logic [$clog2(NUM_REGS)-1:0]   issue_dst_i     [MULTI_ISSUE],
  input  e_functional_unit              issue_rs_i      [MULTI_ISSUE],
  input  logic [NUM_BCAST-1:0]          bcast_valid_i,
  input  logic [DATA_WIDTH-1:0]         bcast_value_i   [NUM_BCAST],
  input  e_functional_unit              bcast_rs_i      [NUM_BCAST],
  input  logic                          flush_i,
  input  logic [$clog2(NUM_REGS)-1:0]   read_reg1_i     [MULTI_ISSUE],
  input  logic [$clog2(NUM_REGS)-1:0]   read_reg2_i     [MULTI_ISSUE],
  output logic [MULTI_ISSUE-1:0]        read_virtual1_o,
  output logic [MULTI_ISSUE-1:0]        read_virtual2_o,
  output logic [DATA_WIDTH-1:0]         read_value1_o   [MULTI_ISSUE],
  output logic [DATA_WIDTH-1:0]         read_value2_o   [MULTI_ISSUE],
  output e_functional_unit              read_tag1_o     [MULTI_ISSUE],
  output e_functional_unit              read_tag2_o     [MULTI_ISSUE],
  output logic [$clog2(NUM_REGS):0]     virtual_count_o
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = IDX_W + 1;

  reg_entry_t              r_regs [NUM_REGS];
  logic [CNT_W-1:0]        r_virtual_count;

  reg_entry_t              w_next [NUM_REGS];
  logic [CNT_W-1:0]        w_next_count;
  logic                    w_hit       [NUM_REGS];
  logic [DATA_WIDTH-1:0]   w_hit_value [NUM_REGS];
  logic                    w_dup_bcast;

  // -------------------------------------------------------------------------
  // Per-register wake-up match against all CDB ports.
  // -------------------------------------------------------------------------
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_match
    regfile_bcast_match #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_BCAST  (NUM_BCAST)
    ) u_match (
      .i_tag         (r_regs[r].rs_id),
      .i_bcast_valid (bcast_valid_i),
      .i_bcast_value (bcast_value_i),
      .i_bcast_rs    (bcast_rs_i),
      .o_hit         (w_hit[r]),
      .o_value       (w_hit_value[r])
    );
  end

  // -------------------------------------------------------------------------
  // Next state. Order matters: broadcasts capture values first, then either
  // the flush clears every virtual bit (issue discarded) or the issue slots
  // re-tag their destinations. Slots are walked low-to-high so the highest
  // slot wins on a shared destination, and an issue overrides a same-cycle
  // wake-up of the same register.
  // -------------------------------------------------------------------------
  always_comb begin
    w_next = r_regs;

    for (int r = 0; r < NUM_REGS; r++) begin
      if (r_regs[r].is_virtual && w_hit[r]) begin
        w_next[r].is_virtual = 1'b0;
        w_next[r].value      = REG_VALUE_W'(w_hit_value[r]);
      end
    end

    if (flush_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        w_next[r].is_virtual = 1'b0;
      end
    end else begin
      for (int i = 0; i < MULTI_ISSUE; i++) begin
        if (issue_wr_en_i[i] && (issue_dst_i[i] != '0)) begin
          w_next[issue_dst_i[i]].is_virtual = 1'b1;
          w_next[issue_dst_i[i]].rs_id      = issue_rs_i[i];
        end
      end
    end

    // Register 0 is hard-wired to zero and never renamed.
    w_next[0] = reset_entry(0, '0);

    w_next_count = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_next_count = w_next_count + CNT_W'(w_next[r].is_virtual);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= reset_entry(r, REG_VALUE_W'(SP_RESET));
      end
      r_virtual_count <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= w_next[r];
      end
      r_virtual_count <= w_next_count;
    end
  end

  assign virtual_count_o = r_virtual_count;

  // -------------------------------------------------------------------------
  // Two valid CDB ports naming the same station in one cycle is illegal; the
  // hardware resolves it to the lowest port, simulation flags it.
  // -------------------------------------------------------------------------
  always_comb begin
    w_dup_bcast = 1'b0;
    for (int b1 = 0; b1 < NUM_BCAST; b1++) begin
      for (int b2 = b1 + 1; b2 < NUM_BCAST; b2++) begin
        if (bcast_valid_i[b1] && bcast_valid_i[b2] &&
            (bcast_rs_i[b1] == bcast_rs_i[b2])) begin
          w_dup_bcast = 1'b1;
        end
      end
    end
  end

  a_no_dup_bcast: assert property (@(posedge clk) disable iff (rst) !w_dup_bcast);

  // -------------------------------------------------------------------------
  // Read ports.
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < MULTI_ISSUE; i++) begin : g_read
    reg_entry_t w_rd1;
    reg_entry_t w_rd2;

    assign w_rd1 = r_regs[read_reg1_i[i]];
    assign w_rd2 = r_regs[read_reg2_i[i]];

    assign read_tag1_o[i] = w_rd1.rs_id;
    assign read_tag2_o[i] = w_rd2.rs_id;

`ifdef REGFILE_BCAST_BYPASS_EN
    logic                  w_byp1_hit;
    logic                  w_byp2_hit;
    logic [DATA_WIDTH-1:0] w_byp1_value;
    logic [DATA_WIDTH-1:0] w_byp2_value;

    regfile_bcast_match #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_BCAST  (NUM_BCAST)
    ) u_byp1 (
      .i_tag         (w_rd1.rs_id),
      .i_bcast_valid (bcast_valid_i),
      .i_bcast_value (bcast_value_i),
      .i_bcast_rs    (bcast_rs_i),
      .o_hit         (w_byp1_hit),
      .o_value       (w_byp1_value)
    );

    regfile_bcast_match #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_BCAST  (NUM_BCAST)
    ) u_byp2 (
      .i_tag         (w_rd2.rs_id),
      .i_bcast_valid (bcast_valid_i),
      .i_bcast_value (bcast_value_i),
      .i_bcast_rs    (bcast_rs_i),
      .o_hit         (w_byp2_hit),
      .o_value       (w_byp2_value)
    );

    // Only a pending operand is bypassed; flush does not gate the bypass.
    assign read_virtual1_o[i] = w_rd1.is_virtual & ~w_byp1_hit;
    assign read_virtual2_o[i] = w_rd2.is_virtual & ~w_byp2_hit;
    assign read_value1_o[i]   = (w_rd1.is_virtual && w_byp1_hit) ? w_byp1_value
                                                                 : w_rd1.value[DATA_WIDTH-1:0];
    assign read_value2_o[i]   = (w_rd2.is_virtual && w_byp2_hit) ? w_byp2_value
                                                                 : w_rd2.value[DATA_WIDTH-1:0];
`else
    assign read_virtual1_o[i] = w_rd1.is_virtual;
    assign read_virtual2_o[i] = w_rd2.is_virtual;
    assign read_value1_o[i]   = w_rd1.value[DATA_WIDTH-1:0];
    assign read_value2_o[i]   = w_rd2.value[DATA_WIDTH-1:0];
`endif
  end

endmodule
